chr_mem_arbiter: RTL and testbench

Single-port arbiter and sequencer for the 8 KB CHR block RAM shared by the PPU-side read path and the SDRAM-to-BRAM loader. Grants one access per slot, drives the BRAM address/data/write-enable, returns read data with a fixed latency and tracks loader fill progress. Produces the `mem_ready` flag that feeds the bus bridge's `init_sdram_data` input.

---
 rtl/chr_mem_arbiter_if.sv | 51 +++++
 rtl/chr_mem_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_chr_mem_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/chr_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// chr_mem_arbiter_if
// Bundle of every non-clock signal around the CHR BRAM arbiter.
//
//   slave  modport : seen by the arbiter (requests, BRAM read data and reload
//                    in; acks, read data, BRAM controls and fill status out)
//   master modport : seen by whatever drives the requests and models the BRAM
//
// Signals
//   rd_req/rd_addr                read request, held until rd_ack
//   rd_ack, rd_valid, rd_data     read accept pulse, data-valid pulse, data
//   wr_req/wr_addr/wr_data        loader write request, held until wr_ack
//   wr_ack                        write performed pulse
//   reload                        one-cycle pulse restarting fill tracking
//   blk_mem_addr/din/we           registered BRAM controls
//   blk_mem_dout                  BRAM read data (1-cycle latency)
//   fill_count, mem_ready         accepted-write count and "BRAM full" flag
// ---------------------------------------------------------------------------
interface chr_mem_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic              reload;
  logic [ADDR_W-1:0] blk_mem_addr;
  logic [DATA_W-1:0] blk_mem_din;
  logic              blk_mem_we;
  logic [DATA_W-1:0] blk_mem_dout;
  logic [ADDR_W:0]   fill_count;
  logic              mem_ready;

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, reload, blk_mem_dout,
    output rd_ack, rd_data, rd_valid, wr_ack,
           blk_mem_addr, blk_mem_din, blk_mem_we, fill_count, mem_ready
  );

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, reload, blk_mem_dout,
    input  rd_ack, rd_data, rd_valid, wr_ack,
           blk_mem_addr, blk_mem_din, blk_mem_we, fill_count, mem_ready
  );
endinterface

// File: rtl/chr_mem_arbiter.sv
// ---------------------------------------------------------------------------
// chr_mem_arbiter
// Single-port arbiter/sequencer for the 8 KB CHR block RAM shared by the PPU
// read path and the SDRAM-to-BRAM loader. One access per slot:
//   read  : IDLE -> RD -> RD_WAIT -> RD_DONE -> IDLE   (rd_ack c1, rd_valid c3)
//   write : IDLE -> WR -> IDLE                         (wr_ack/we c1)
// fill_count counts accepted writes since reset/reload and saturates at
// 2**ADDR_W; mem_ready is high once the count is full. Until then reads return
// zero so the PPU never sees a half-loaded CHR image.
//
// Ports
//   clk   system clock, all logic on the rising edge
//   rst   synchronous active-high reset
//   bus   chr_mem_arbiter_if.slave (request/ack, BRAM controls, fill status)
//
// Parameters
//   ADDR_W      BRAM address width (13 -> 8192 bytes)
//   DATA_W      BRAM data width
//   STARVE_MAX  consecutive read grants allowed while a write waits, 1..15
//
// Build option
//   CHR_ARB_STARVE_GUARD_EN  when defined, a 4-bit starvation counter forces a
//                            write grant after STARVE_MAX reads that were made
//                            while wr_req was pending. Undefined: strict read
//                            priority, no counter.
// ---------------------------------------------------------------------------
module chr_mem_arbiter #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  chr_mem_arbiter_if.slave   bus
);

  localparam logic [ADDR_W:0] FILL_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] FILL_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  // The starvation counter is 4 bits wide; reject values it cannot reach.
  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("chr_mem_arbiter: STARVE_MAX must be in 1..15");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RD_WAIT,
    S_RD_DONE,
    S_WR
  } state_t;

  // Saturating fill-count increment: stops at a full BRAM.
  function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] cnt);
    return (cnt == FILL_FULL) ? cnt : cnt + FILL_ONE;
  endfunction

  // Reads of a partially loaded BRAM return zero.
  function automatic logic [DATA_W-1:0] gate_rd(input logic              ready,
                                                 input logic [DATA_W-1:0] din);
    return ready ? din : '0;
  endfunction

  state_t            r_state;
  logic              r_rd_ack;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_wr_ack;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_din;
  logic              r_mem_we;
  logic [ADDR_W:0]   r_fill_count;
  logic              r_mem_ready;

  logic              w_grant_rd;
  logic              w_grant_wr;
  logic [ADDR_W:0]   w_fill_next;

  assign w_fill_next = sat_inc(r_fill_count);

`ifdef CHR_ARB_STARVE_GUARD_EN
  localparam logic [3:0] STARVE_CNT_MAX = 4'(STARVE_MAX);

  logic [3:0] r_starve_cnt;
  logic       w_starve_trip;

  // Once STARVE_MAX reads have overtaken a waiting write, the write wins.
  assign w_starve_trip = bus.wr_req && (r_starve_cnt == STARVE_CNT_MAX);
  assign w_grant_rd    = bus.rd_req && !w_starve_trip;
  assign w_grant_wr    = bus.wr_req && !w_grant_rd;

  // Counts read grants made over a pending write; any write grant or an
  // IDLE cycle with no write pending starts the window afresh.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= 4'd0;
    end else if (r_state == S_IDLE) begin
      if (!bus.wr_req || w_grant_wr) begin
        r_starve_cnt <= 4'd0;
      end else if (w_grant_rd) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
    end
  end
`else
  // Strict read priority: the loader only gets slots the PPU leaves free.
  assign w_grant_rd = bus.rd_req;
  assign w_grant_wr = bus.wr_req && !bus.rd_req;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_rd_ack     <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_rd_data    <= '0;
      r_wr_ack     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_din    <= '0;
      r_mem_we     <= 1'b0;
      r_fill_count <= '0;
      r_mem_ready  <= 1'b0;
    end else begin
      // Pulses default low; each state raises only what it owns.
      r_rd_ack   <= 1'b0;
      r_rd_valid <= 1'b0;
      r_wr_ack   <= 1'b0;
      r_mem_we   <= 1'b0;

      case (r_state)
        // IDLE: arbitrate; outputs for the granted slot are set here so they
        // are registered and visible in the first cycle of that slot.
        S_IDLE: begin
          if (w_grant_rd) begin
            r_state    <= S_RD;
            r_mem_addr <= bus.rd_addr;
            r_rd_ack   <= 1'b1;
          end else if (w_grant_wr) begin
            r_state    <= S_WR;
            r_mem_addr <= bus.wr_addr;
            r_mem_din  <= bus.wr_data;
            r_mem_we   <= 1'b1;
            r_wr_ack   <= 1'b1;
          end
        end

        // RD: BRAM samples the read address at the end of this cycle.
        S_RD: begin
          r_state <= S_RD_WAIT;
        end

        // RD_WAIT: BRAM data is on blk_mem_dout; capture it for RD_DONE.
        S_RD_WAIT: begin
          r_state    <= S_RD_DONE;
          r_rd_data  <= gate_rd(r_mem_ready, bus.blk_mem_dout);
          r_rd_valid <= 1'b1;
        end

        // RD_DONE: rd_data/rd_valid presented to the requester.
        S_RD_DONE: begin
          r_state <= S_IDLE;
        end

        // WR: BRAM write happens this cycle; count it.
        S_WR: begin
          r_state      <= S_IDLE;
          r_fill_count <= w_fill_next;
          r_mem_ready  <= (w_fill_next == FILL_FULL);
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase

      // Reload overrides the count update even in a WR cycle: that write
      // still reaches the BRAM but starts a new, empty fill.
      if (bus.reload) begin
        r_fill_count <= '0;
        r_mem_ready  <= 1'b0;
      end
    end
  end

  assign bus.rd_ack       = r_rd_ack;
  assign bus.rd_valid     = r_rd_valid;
  assign bus.rd_data      = r_rd_data;
  assign bus.wr_ack       = r_wr_ack;
  assign bus.blk_mem_addr = r_mem_addr;
  assign bus.blk_mem_din  = r_mem_din;
  assign bus.blk_mem_we   = r_mem_we;
  assign bus.fill_count   = r_fill_count;
  assign bus.mem_ready    = r_mem_ready;

endmodule

// File: tb/tb_chr_mem_arbiter.sv
module tb_chr_mem_arbiter;
  localparam int ADDR_W     = 13;
  localparam int DATA_W     = 8;
  localparam int STARVE_MAX = 4;
  localparam int FULL       = 8192;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  chr_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  chr_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural BRAM: synchronous read, 1-cycle latency, read-before-write.
  logic [7:0] ram [0:FULL-1];
  always @(posedge clk) begin
    if (bus.blk_mem_we) ram[bus.blk_mem_addr] <= bus.blk_mem_din;
    bus.blk_mem_dout <= ram[bus.blk_mem_addr];
  end

  // Reference model: expected BRAM contents and accepted-write count.
  logic [7:0] exp_mem [0:FULL-1];
  int exp_count;
  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    bit          wr;
    logic [12:0] addr;
    logic [7:0]  data;
    logic [7:0]  exp_rd;
    int          exp_fill;
    bit          exp_ready;
  } vec_t;
  vec_t vecs [7];

  function automatic bit exp_ready();
    return exp_count == FULL;
  endfunction

  function automatic logic [7:0] exp_read(input logic [12:0] a);
    return exp_ready() ? exp_mem[a] : 8'h00;
  endfunction

  task automatic model_write(input logic [12:0] a, input logic [7:0] d);
    exp_mem[a] = d;
    if (exp_count < FULL) exp_count++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " rd_ack"},     bus.rd_ack, 0);
    chk({tag, " rd_valid"},   bus.rd_valid, 0);
    chk({tag, " wr_ack"},     bus.wr_ack, 0);
    chk({tag, " we"},         bus.blk_mem_we, 0);
    chk({tag, " mem_ready"},  bus.mem_ready, 0);
    chk({tag, " rd_data"},    bus.rd_data, 0);
    chk({tag, " addr"},       bus.blk_mem_addr, 0);
    chk({tag, " din"},        bus.blk_mem_din, 0);
    chk({tag, " fill_count"}, bus.fill_count, 0);
  endtask

  // Issue one read from IDLE; returns with the DUT back in IDLE.
  task automatic do_read(input logic [12:0] a, input logic [7:0] exp, input string tag);
    int ack_at, vld_at, n_ack;
    logic [7:0] got;
    ack_at = -1; vld_at = -1; n_ack = 0; got = '0;
    bus.rd_addr = a;
    bus.rd_req  = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (bus.rd_ack === 1'b1) begin
        n_ack++;
        if (ack_at < 0) ack_at = c;
        bus.rd_req = 1'b0;
      end
      if (c == 1) begin
        chk({tag, " rd addr"}, bus.blk_mem_addr, a);
        chk({tag, " rd we"},   bus.blk_mem_we, 0);
      end
      if (bus.rd_valid === 1'b1) begin
        vld_at = c;
        got = bus.rd_data;
        break;
      end
    end
    bus.rd_req = 1'b0;
    chk({tag, " ack latency"},   ack_at, 1);
    chk({tag, " ack count"},     n_ack, 1);
    chk({tag, " valid latency"}, vld_at, 3);
    chk({tag, " rd_data"},       got, exp);
    step();
    chk({tag, " valid pulse"},   bus.rd_valid, 0);
    chk({tag, " rd_data held"},  bus.rd_data, exp);
  endtask

  // Issue one write from IDLE; returns with the DUT back in IDLE.
  task automatic do_write(input logic [12:0] a, input logic [7:0] d, input string tag);
    bit ready_before;
    ready_before = exp_ready();
    bus.wr_addr = a;
    bus.wr_data = d;
    bus.wr_req  = 1'b1;
    step();
    chk({tag, " wr_ack"},      bus.wr_ack, 1);
    chk({tag, " we"},          bus.blk_mem_we, 1);
    chk({tag, " wr addr"},     bus.blk_mem_addr, a);
    chk({tag, " din"},         bus.blk_mem_din, d);
    chk({tag, " ready in WR"}, bus.mem_ready, ready_before);
    bus.wr_req = 1'b0;
    model_write(a, d);
    step();
    chk({tag, " ack pulse"},   bus.wr_ack, 0);
    chk({tag, " we pulse"},    bus.blk_mem_we, 0);
    chk({tag, " fill_count"},  bus.fill_count, exp_count);
    chk({tag, " mem_ready"},   bus.mem_ready, exp_ready());
  endtask

  task automatic random_phase(input int n_ops, input bit allow_reload, input string tag);
    for (int i = 0; i < n_ops; i++) begin
      int r;
      logic [12:0] a;
      logic [7:0]  d;
      r = $urandom_range(0, 99);
      a = 13'($urandom_range(0, FULL - 1));
      d = 8'($urandom);
      if (allow_reload && r < 4) begin
        bus.reload = 1'b1;
        step();
        bus.reload = 1'b0;
        exp_count = 0;
        chk({tag, " reload fill"},  bus.fill_count, 0);
        chk({tag, " reload ready"}, bus.mem_ready, 0);
      end else if (r < 50) begin
        do_write(a, d, tag);
      end else begin
        do_read(a, exp_read(a), tag);
      end
      repeat ($urandom_range(0, 2)) step();
    end
  endtask

  initial begin
    bus.rd_req = 1'b0; bus.rd_addr = '0;
    bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.reload = 1'b0;
    for (int i = 0; i < FULL; i++) begin
      ram[i] = 8'h00;
      exp_mem[i] = 8'h00;
    end
    ram[5] = 8'hA5;
    exp_mem[5] = 8'hA5;
    exp_count = 0;

    vecs[0] = '{1'b0, 13'h1234, 8'h00, 8'h34, FULL, 1'b1};
    vecs[1] = '{1'b1, 13'h0010, 8'h77, 8'h00, FULL, 1'b1};
    vecs[2] = '{1'b0, 13'h0010, 8'h00, 8'h77, FULL, 1'b1};
    vecs[3] = '{1'b0, 13'h1FFF, 8'h00, 8'hFF, FULL, 1'b1};
    vecs[4] = '{1'b1, 13'h1FFF, 8'h00, 8'h00, FULL, 1'b1};
    vecs[5] = '{1'b0, 13'h1FFF, 8'h00, 8'h00, FULL, 1'b1};
    vecs[6] = '{1'b0, 13'h00AA, 8'h00, 8'hAA, FULL, 1'b1};

    // Reset state
    repeat (3) step();
    chk_reset_outputs("reset");
    rst = 1'b0;
    step();
    chk_reset_outputs("post-reset idle");

    // Read before any fill returns zero
    do_read(13'h0005, 8'h00, "empty read");

    // Full fill, data = addr[7:0]
    for (int i = 0; i < FULL; i++) begin
      do_write(13'(i), 8'(i), "fill");
    end
    chk("fill done count", bus.fill_count, FULL);
    chk("fill done ready", bus.mem_ready, 1);

    // Table of post-fill transactions
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].data, $sformatf("vec%0d", i));
      else            do_read(vecs[i].addr, vecs[i].exp_rd, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d fill", i),  bus.fill_count, vecs[i].exp_fill);
      chk($sformatf("vec%0d ready", i), bus.mem_ready, vecs[i].exp_ready);
    end

    // Random traffic on a full BRAM
    random_phase(300, 1'b0, "rand full");

    // Reload coincident with a WR cycle
    chk("pre-reload ready", bus.mem_ready, 1);
    bus.wr_addr = 13'h0ABC;
    bus.wr_data = 8'h5A;
    bus.wr_req  = 1'b1;
    step();
    chk("reload-wr wr_ack", bus.wr_ack, 1);
    chk("reload-wr we",     bus.blk_mem_we, 1);
    bus.wr_req = 1'b0;
    bus.reload = 1'b1;
    step();
    bus.reload = 1'b0;
    exp_mem[13'h0ABC] = 8'h5A;
    exp_count = 0;
    chk("reload-wr fill",  bus.fill_count, 0);
    chk("reload-wr ready", bus.mem_ready, 0);
    chk("reload-wr bram",  ram[13'h0ABC], 8'h5A);
    do_read(13'h0ABC, 8'h00, "after reload read");

    // Random traffic with reloads, counting from empty
    random_phase(100, 1'b1, "rand reload");

    // Both requesters held continuously
    begin
      bit grants[$];
      int n_vld, n_rdg, n_wrg;
      n_vld = 0; n_rdg = 0; n_wrg = 0;
      bus.rd_addr = 13'h0100;
      bus.wr_addr = 13'h0200;
      bus.wr_data = 8'h3C;
      bus.rd_req  = 1'b1;
      bus.wr_req  = 1'b1;
      for (int c = 0; c < 68; c++) begin
        if (c == 60) begin
          bus.rd_req = 1'b0;
          bus.wr_req = 1'b0;
        end
        step();
        if (bus.rd_ack === 1'b1) begin
          grants.push_back(1'b0);
          n_rdg++;
        end
        if (bus.wr_ack === 1'b1) begin
          grants.push_back(1'b1);
          n_wrg++;
          model_write(13'h0200, 8'h3C);
        end
        if (bus.rd_valid === 1'b1) begin
          n_vld++;
          chk("contend rd_data", bus.rd_data, exp_read(13'h0100));
        end
      end
      chk("contend valids", n_vld, n_rdg);
      chk("contend enough grants", (grants.size() >= 12) ? 1 : 0, 1);
`ifdef CHR_ARB_STARVE_GUARD_EN
      for (int k = 0; k < grants.size(); k++) begin
        chk($sformatf("contend grant%0d is_write", k), grants[k],
            ((k % (STARVE_MAX + 1)) == STARVE_MAX) ? 1 : 0);
      end
`else
      chk("contend wr_acks", n_wrg, 0);
`endif
      chk("contend fill", bus.fill_count, exp_count);
    end

    // Reset while in RD_WAIT
    begin
      int vcount;
      vcount = 0;
      bus.rd_addr = 13'h0005;
      bus.rd_req  = 1'b1;
      step();
      chk("rst-rd ack", bus.rd_ack, 1);
      bus.rd_req = 1'b0;
      step();
      chk("rst-rd no early valid", bus.rd_valid, 0);
      rst = 1'b1;
      step();
      chk_reset_outputs("rst-rd");
      rst = 1'b0;
      exp_count = 0;
      for (int c = 0; c < 4; c++) begin
        step();
        if (bus.rd_valid === 1'b1) vcount++;
      end
      chk("rst-rd stray valid", vcount, 0);
      do_read(13'h0005, 8'h00, "post-rst read");
      do_write(13'h0123, 8'h9E, "post-rst write");
      chk("post-rst fill one", bus.fill_count, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
